sc_stream_decoder: RTL
======================

// Module: sc_stream_decoder
// PURPOSE
//  Stochastic-to-binary decoder on the output side of the canonical-form AND-OR network.
//  Counts the 1s on each of NUM_OUTPUTS bitstreams over a window of STREAM_LEN valid samples.
//  Presents the per-output counts as binary values through a valid/ready handshake.
//  Each value estimates stream probability * STREAM_LEN.
// PARAMETERS
//  NUM_OUTPUTS  2    number of parallel bitstreams decoded (matches the canonical-form output count)
//  STREAM_LEN   256  samples per decode window; >=1, need not be a power of 2
//  CNT_W        $clog2(STREAM_LEN+1)  count width (derived; holds 0..STREAM_LEN inclusive)
// PORTS
//  clk           in   1                   clock, all state on rising edge
//  rst           in   1                   synchronous, active-high reset
//  start         in   1                   begin a decode window (accepted only in IDLE)
//  stream_valid  in   1                   streams carry a valid sample this cycle
//  streams       in   NUM_OUTPUTS         one bit per stochastic stream, bit k = output k
//  busy          out  1                   1 in COUNT state
//  result_valid  out  1                   counts holds a completed window result
//  result_ready  in   1                   consumer accepts result when result_valid & result_ready
//  counts        out  NUM_OUTPUTS*CNT_W   count k at [k*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset (rst=1 at clock edge), regardless of state:
//   - state=IDLE; sample counter, all accumulators and counts = 0
//   - busy=0, result_valid=0
//  FSM states: IDLE, COUNT, DONE.
//   - IDLE: start=1 -> COUNT next cycle; accumulators and sample counter cleared on that edge.
//     streams/stream_valid ignored in IDLE, including the start cycle itself.
//   - COUNT: on each edge with stream_valid=1:
//     acc[k] += streams[k] for every k; sample counter +1.
//     stream_valid=0 is a stall: no state change. start ignored in COUNT.
//   - When the sample accepted brings the sample counter to STREAM_LEN:
//     that sample is included; acc values are copied to counts; state -> DONE.
//     result_valid=1 the cycle after the last sample (latency 1 from last sample edge).
//   - DONE: counts and result_valid held stable until result_valid & result_ready at an edge,
//     then result_valid=0 and state -> IDLE. start in DONE is ignored (not queued).
//     Inputs ignored. counts keeps its last value after handshake until the next window completes.
//  Arithmetic:
//   - accumulators unsigned CNT_W bits; cannot overflow (max STREAM_LEN fits CNT_W)
//   - sample counter same width, compares == STREAM_LEN-1 on the accepting edge
//  Boundaries:
//   - all-ones stream -> STREAM_LEN; all-zeros -> 0
//   - STREAM_LEN=1: DONE after exactly one valid sample
//   - rst mid-COUNT or in DONE discards the partial or pending result; counts -> 0
//   - back-to-back: earliest new start is the cycle after the handshake (IDLE)
// TESTING
//  1. Reset with result pending: rst in DONE -> next cycle result_valid=0, busy=0, counts=0.
//  2. Full window, defaults: start, then 256 valid samples.
//     streams[0]=1 always, streams[1]=1 on every 4th sample -> counts={64,256}.
//     result_valid rises the cycle after the 256th sample.
//  3. Stalls: stream_valid randomly 0 about 50% during a window, streams[0]=1 when valid
//     -> count0=256; window ends only after 256 valid cycles.
//  4. Backpressure: result_ready=0 for 10 cycles after result_valid.
//     -> counts stable and result_valid held; start pulses ignored.
//     Then result_ready=1 -> IDLE next cycle.
//  5. Abort: rst after 100 valid samples, then a fresh start and 256 all-ones samples -> counts={256,256}.
//  6. Canonical-form loopback: fed from a canonical-form block with weight 3/4 on an always-on variable.
//     -> count within +-16 of 192 over a 256-sample window; STREAM_LEN=1 build: single sample 1 -> count=1.

Source files
------------

// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - stochastic-to-binary decoder: counts ones per stream over a window
// of STREAM_LEN valid samples, then presents the per-stream counts over a valid/ready handshake.
module sc_stream_decoder #(
  parameter int NUM_OUTPUTS = 2,
  parameter int STREAM_LEN  = 256,
  parameter int CNT_W       = $clog2(STREAM_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stream_valid,
  input  logic [NUM_OUTPUTS-1:0]       streams,
  output logic                         busy,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [NUM_OUTPUTS*CNT_W-1:0] counts
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(STREAM_LEN - 1);

  state_t                              state;
  logic [CNT_W-1:0]                    sample_cnt;
  logic [NUM_OUTPUTS-1:0][CNT_W-1:0]   acc;
  logic [NUM_OUTPUTS-1:0][CNT_W-1:0]   counts_q;

  assign counts = counts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sample_cnt   <= '0;
      acc          <= '0;
      counts_q     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= COUNT;
            busy       <= 1'b1;
            sample_cnt <= '0;
            acc        <= '0;
          end
        end
        COUNT: begin
          if (stream_valid) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
              acc[k] <= acc[k] + CNT_W'(streams[k]);
            end
            sample_cnt <= sample_cnt + CNT_W'(1);
            // The closing sample is folded straight into the published result.
            if (sample_cnt == LAST_SAMPLE) begin
              for (int k = 0; k < NUM_OUTPUTS; k++) begin
                counts_q[k] <= acc[k] + CNT_W'(streams[k]);
              end
              state        <= DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
